serial_receiver: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of serial_transmitter, using the same CLK_IN/BAUD clock-division scheme.
- Oversamples RX on clk, recovers LSB-first bytes and pushes them into an internal fifo instance.
- The consumer drains the FIFO with the same valid/dout/rd_en handshake the transmitter uses on its own FIFO.

---
 rtl/serial_receiver_pkg.sv | 15 +
 rtl/serial_receiver_if.sv | 23 ++
 rtl/serial_receiver_fifo.sv | 50 +++++
 rtl/serial_receiver.sv | 117 +++++++++++
 tb/tb_serial_receiver.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/serial_receiver_pkg.sv
// serial_receiver_pkg: shared 8N1 constants and the one-hot receiver state type.
package serial_receiver_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 9;

    typedef enum logic [4:0] {
        RX_IDLE        = 5'b00001,
        RX_START_CHECK = 5'b00010,
        RX_DATA        = 5'b00100,
        RX_STOP        = 5'b01000,
        RX_BREAK_WAIT  = 5'b10000
    } rx_state_e;

endpackage

// File: rtl/serial_receiver_if.sv
// serial_receiver_if: consumer-side FIFO drain handshake plus error pulses.
interface serial_receiver_if;
    import serial_receiver_pkg::*;

    logic                 rd_en;
    logic [DATA_BITS-1:0] dout;
    logic                 valid;
    logic                 empty;
    logic [CNT_W-1:0]     data_count;
    logic                 framing_err;
    logic                 overrun_err;

    modport master (
        output rd_en,
        input  dout, valid, empty, data_count, framing_err, overrun_err
    );

    modport slave (
        input  rd_en,
        output dout, valid, empty, data_count, framing_err, overrun_err
    );

endinterface

// File: rtl/serial_receiver_fifo.sv
// serial_receiver_fifo: show-ahead synchronous FIFO; valid rises the cycle after a write.
module serial_receiver_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             empty,
    output logic             full,
    output logic [8:0]       data_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_wr, do_rd;

    assign valid = count_q != '0;
    assign empty = !valid;
    assign full  = count_q == CW'(DEPTH);
    assign dout  = mem[rd_ptr_q];
    // With DEPTH=512 a completely full FIFO reads 0 here; full/empty remain exact.
    assign data_count = 9'(count_q);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && valid;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 UART receiver oversampling RX on clk and queueing bytes in a FIFO.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int CLK_IN = 0,
    parameter int BAUD   = 0,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              RX,
    serial_receiver_if.slave  bus
);
    localparam int          COUNT_FOR_BAUD = CLK_IN / ((BAUD == 0) ? 1 : BAUD);
    localparam logic [15:0] FULL_CNT       = 16'(COUNT_FOR_BAUD);
    localparam logic [15:0] HALF_CNT       = 16'(COUNT_FOR_BAUD / 2);

    rx_state_e            state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_pos_q, bit_pos_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 wr_q, wr_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;
    logic                 fifo_full;

    always_ff @(posedge clk) begin
        if (srst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_pos_q <= '0;
            shift_q   <= '0;
            wr_q      <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_pos_q <= bit_pos_d;
            shift_q   <= shift_d;
            wr_q      <= wr_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_pos_d = bit_pos_q;
        shift_d   = shift_q;
        wr_d      = 1'b0;
        ferr_d    = 1'b0;
        oerr_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d   = '0;
                state_d = rx_s_q ? RX_IDLE : RX_START_CHECK;
            end
            RX_START_CHECK: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_pos_d = '0;
                    state_d   = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == FULL_CNT) begin
                    cnt_d             = '0;
                    shift_d[bit_pos_q] = rx_s_q;
                    bit_pos_d         = bit_pos_q + 3'd1;
                    state_d           = (bit_pos_q == 3'(DATA_BITS - 1)) ? RX_STOP : RX_DATA;
                end
            end
            RX_STOP: begin
                cnt_d = cnt_q + 16'd1;
                // Leaving at mid stop bit lets a back-to-back start edge be seen in IDLE.
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    wr_d    = rx_s_q && !fifo_full;
                    oerr_d  = rx_s_q && fifo_full;
                    ferr_d  = !rx_s_q;
                    state_d = rx_s_q ? RX_IDLE : RX_BREAK_WAIT;
                end
            end
            RX_BREAK_WAIT: state_d = rx_s_q ? RX_IDLE : RX_BREAK_WAIT;
            default:       state_d = RX_IDLE;
        endcase
    end

    assign bus.framing_err = ferr_q;
    assign bus.overrun_err = oerr_q;

    serial_receiver_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .srst       (srst),
        .wr_en      (wr_q),
        .din        (shift_q),
        .rd_en      (bus.rd_en),
        .dout       (bus.dout),
        .valid      (bus.valid),
        .empty      (bus.empty),
        .full       (fifo_full),
        .data_count (bus.data_count)
    );

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: scoreboard bench driving 8N1 frames at 100 cycles/bit into two receivers.
`timescale 1ns/1ps
module tb_serial_receiver;
    import serial_receiver_pkg::*;

    localparam int BIT = 100;

    logic clk = 1'b0;
    logic srst = 1'b1;
    logic RX = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   m_ferr = 0, m_oerr = 0, s_ferr = 0, s_oerr = 0;
    logic [7:0] sb [$];

    serial_receiver_if m_if ();
    serial_receiver_if s_if ();

    serial_receiver #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DEPTH(512)) u_dut (
        .clk (clk), .srst (srst), .RX (RX), .bus (m_if.slave)
    );
    serial_receiver #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DEPTH(4)) u_small (
        .clk (clk), .srst (srst), .RX (RX), .bus (s_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_if.framing_err) m_ferr++;
        if (m_if.overrun_err) m_oerr++;
        if (s_if.framing_err) s_ferr++;
        if (s_if.overrun_err) s_oerr++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BIT) @(negedge clk);
        end
        RX = stop_bit;
        repeat (BIT) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk) srst = 1'b1;
        @(negedge clk) srst = 1'b0;
    endtask

    task automatic drain_main(input string tag);
        logic [7:0] exp;
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            for (int i = 0; i < 3000 && !m_if.valid; i++) @(negedge clk);
            chk(tag, {m_if.valid, m_if.dout}, {1'b1, exp});
            m_if.rd_en = 1'b1;
            @(negedge clk);
            m_if.rd_en = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int f0, o0;
        m_if.rd_en = 1'b0;
        s_if.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        chk("rst_valid", m_if.valid, 1'b0);
        chk("rst_empty", m_if.empty, 1'b1);
        chk("rst_count", m_if.data_count, 9'd0);
        chk("rst_errs", {m_if.framing_err, m_if.overrun_err}, 2'b00);
        chk("rst_state", 32'(u_dut.state_q), 32'(RX_IDLE));

        send(8'hA5, 1'b1); sb.push_back(8'hA5);
        repeat (20) @(negedge clk);
        chk("a5_count", m_if.data_count, 9'd1);
        chk("a5_valid", m_if.valid, 1'b1);
        drain_main("a5_dout");
        chk("a5_errs", 32'(m_ferr + m_oerr), 32'd0);
        chk("a5_drained", m_if.data_count, 9'd0);

        RX = 1'b0;
        repeat (30) @(negedge clk);
        RX = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_count", m_if.data_count, 9'd0);
        chk("glitch_idle", 32'(u_dut.state_q), 32'(RX_IDLE));
        send(8'h3C, 1'b1); sb.push_back(8'h3C);
        drain_main("glitch_next");

        f0 = m_ferr;
        send(8'h3C, 1'b0);
        RX = 1'b0;
        repeat (2000) @(negedge clk);
        RX = 1'b1;
        repeat (200) @(negedge clk);
        chk("brk_ferr", 32'(m_ferr - f0), 32'd1);
        chk("brk_count", m_if.data_count, 9'd0);
        send(8'h11, 1'b1); sb.push_back(8'h11);
        drain_main("brk_next");

        foreach (sb[i]) chk("sb_empty", 32'(i), 32'hffff);
        send(8'h00, 1'b1); sb.push_back(8'h00);
        send(8'hFF, 1'b1); sb.push_back(8'hFF);
        send(8'h55, 1'b1); sb.push_back(8'h55);
        repeat (20) @(negedge clk);
        chk("b2b_count", m_if.data_count, 9'd3);
        drain_main("b2b_dout");
        chk("b2b_drained", m_if.data_count, 9'd0);

        pulse_reset();
        o0 = s_oerr;
        for (int k = 1; k <= 5; k++) begin
            send(8'(k), 1'b1);
            sb.push_back(8'(k));
        end
        repeat (20) @(negedge clk);
        chk("ovr_count", s_if.data_count, 9'd4);
        chk("ovr_pulse", 32'(s_oerr - o0), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovr_dout", {s_if.valid, s_if.dout}, {1'b1, 8'(k)});
            s_if.rd_en = 1'b1;
            @(negedge clk);
            s_if.rd_en = 1'b0;
        end
        chk("ovr_empty", s_if.empty, 1'b1);
        drain_main("ovr_main");

        f0 = m_ferr;
        o0 = m_oerr;
        RX = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        RX = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        pulse_reset();
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        chk("abort_empty", m_if.empty, 1'b1);
        chk("abort_count", m_if.data_count, 9'd0);
        chk("abort_errs", 32'((m_ferr - f0) + (m_oerr - o0)), 32'd0);
        send(8'h7E, 1'b1); sb.push_back(8'h7E);
        drain_main("abort_next");
        chk("final_count", m_if.data_count, 9'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
